// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage with a single-outstanding-request memory port, a
// small prefetch FIFO and the IF/ID pipeline register.
//
// Memory handshake: imem_req is a request qualifier and imem_ack is its
// acceptance; a word transfers at a posedge where imem_req && imem_ack are both
// high, and imem_data is valid in that same cycle. While imem_req is high and
// not yet acknowledged, imem_addr does not change. A redirect or reset in the
// current cycle withdraws the request, so any ack seen then is ignored.
//
// Configuration macro: FETCH_PREFETCH_BUF_EN
//   undefined : prefetch FIFO depth 1
//   defined   : prefetch FIFO depth 2
//
// Ports:
//   clk        in   clock, all state updates on posedge
//   rst        in   synchronous active-high reset
//   pc_en      in   1 = ID accepts a new instruction, 0 = stall (hold IF/ID)
//   pc_sel     in   00/11 sequential, 01 redirect to br_target, 10 redirect to lr
//   br_target  in   branch target address
//   lr_we      in   load link register with id_pc + 1
//   imem_req   out  fetch request
//   imem_addr  out  fetch address (fetch PC)
//   imem_ack   in   request accepted, imem_data valid
//   imem_data  in   returned instruction
//   id_ins     out  IF/ID instruction
//   id_pc      out  address of id_ins
//   id_valid   out  IF/ID holds a live instruction
//   lr         out  link register
// -----------------------------------------------------------------------------
module fetch_stage (
    input  logic       clk,
    input  logic       rst,
    input  logic       pc_en,
    input  logic [1:0] pc_sel,
    input  logic [7:0] br_target,
    input  logic       lr_we,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ack,
    input  logic [7:0] imem_data,
    output logic [7:0] id_ins,
    output logic [7:0] id_pc,
    output logic       id_valid,
    output logic [7:0] lr
);

`ifdef FETCH_PREFETCH_BUF_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    logic [7:0] fpc_q,      fpc_d;
    logic [7:0] lr_q,       lr_d;
    logic [7:0] id_ins_q,   id_ins_d;
    logic [7:0] id_pc_q,    id_pc_d;
    logic       id_valid_q, id_valid_d;
    logic [1:0] cnt_q,      cnt_d;
    logic [7:0] fifo_ins_q [DEPTH];
    logic [7:0] fifo_ins_d [DEPTH];
    logic [7:0] fifo_pc_q  [DEPTH];
    logic [7:0] fifo_pc_d  [DEPTH];

    logic       redirect;
    logic       accept;
    logic       fifo_empty;
    logic       direct;
    logic       push;
    logic       pop;
    logic [1:0] wr_idx;

    assign redirect   = (pc_sel == 2'b01) || (pc_sel == 2'b10);
    assign fifo_empty = (cnt_q == 2'd0);

    // Room is judged on FIFO occupancy alone (not on pc_en), so a request
    // once raised stays raised until acknowledged even if a stall arrives.
    assign imem_req   = !rst && !redirect && (cnt_q < DEPTH_C);
    assign accept     = imem_req && imem_ack;

    // Bypass the FIFO when it is empty and the IF/ID slot is free this cycle.
    assign direct     = accept && fifo_empty && (pc_en || !id_valid_q);
    assign push       = accept && !direct;
    assign pop        = pc_en && !fifo_empty;
    // A simultaneous pop shifts entries down by one, so the tail moves too.
    assign wr_idx     = pop ? (cnt_q - 2'd1) : cnt_q;

    always_comb begin
        fpc_d      = fpc_q;
        lr_d       = lr_q;
        id_ins_d   = id_ins_q;
        id_pc_d    = id_pc_q;
        id_valid_d = id_valid_q;
        cnt_d      = cnt_q;
        fifo_ins_d = fifo_ins_q;
        fifo_pc_d  = fifo_pc_q;

        // A same-cycle redirect to lr reads lr_q, i.e. the old value.
        if (lr_we) begin
            lr_d = id_pc_q + 8'd1;
        end

        if (redirect) begin
            fpc_d      = (pc_sel == 2'b01) ? br_target : lr_q;
            id_valid_d = 1'b0;
            cnt_d      = 2'd0;
        end else begin
            if (accept) begin
                fpc_d = fpc_q + 8'd1;
            end

            if (pc_en) begin
                if (!fifo_empty) begin
                    id_ins_d   = fifo_ins_q[0];
                    id_pc_d    = fifo_pc_q[0];
                    id_valid_d = 1'b1;
                end else if (direct) begin
                    id_ins_d   = imem_data;
                    id_pc_d    = fpc_q;
                    id_valid_d = 1'b1;
                end else begin
                    id_valid_d = 1'b0;
                end
            end else if (direct) begin
                // Stalled but the slot is empty: fill it instead of buffering.
                id_ins_d   = imem_data;
                id_pc_d    = fpc_q;
                id_valid_d = 1'b1;
            end

            if (pop) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    fifo_ins_d[i] = fifo_ins_q[i+1];
                    fifo_pc_d[i]  = fifo_pc_q[i+1];
                end
            end

            if (push) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (wr_idx == 2'(i)) begin
                        fifo_ins_d[i] = imem_data;
                        fifo_pc_d[i]  = fpc_q;
                    end
                end
            end

            cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q      <= 8'd0;
            lr_q       <= 8'd0;
            id_ins_q   <= 8'd0;
            id_pc_q    <= 8'd0;
            id_valid_q <= 1'b0;
            cnt_q      <= 2'd0;
            fifo_ins_q <= '{default: 8'd0};
            fifo_pc_q  <= '{default: 8'd0};
        end else begin
            fpc_q      <= fpc_d;
            lr_q       <= lr_d;
            id_ins_q   <= id_ins_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
            cnt_q      <= cnt_d;
            fifo_ins_q <= fifo_ins_d;
            fifo_pc_q  <= fifo_pc_d;
        end
    end

    assign imem_addr = fpc_q;
    assign id_ins    = id_ins_q;
    assign id_pc     = id_pc_q;
    assign id_valid  = id_valid_q;
    assign lr        = lr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. The instruction memory model either answers
// every request in the same cycle with data equal to the address (auto mode)
// or is driven by hand (manual mode) to produce late or stray acks. Expected
// IF/ID contents are pushed to exp_q as stimulus is driven and popped when
// the stage presents them.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

`ifdef FETCH_PREFETCH_BUF_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic       clk;
    logic       rst;
    logic       pc_en;
    logic [1:0] pc_sel;
    logic [7:0] br_target;
    logic       lr_we;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [7:0] id_ins;
    logic [7:0] id_pc;
    logic       id_valid;
    logic [7:0] lr;

    logic       mem_auto;
    logic       ack_man;
    logic [7:0] data_man;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_ack  = mem_auto ? imem_req  : ack_man;
    assign imem_data = mem_auto ? imem_addr : data_man;

    fetch_stage dut (
        .clk       (clk),
        .rst       (rst),
        .pc_en     (pc_en),
        .pc_sel    (pc_sel),
        .br_target (br_target),
        .lr_we     (lr_we),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .id_ins    (id_ins),
        .id_pc     (id_pc),
        .id_valid  (id_valid),
        .lr        (lr)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_acc;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Pop the next expected instruction (data == address) and compare IF/ID.
    task automatic check_id(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s observed=id_pc %02h expected=<queue empty>", tag, id_pc);
        end else begin
            e = exp_q.pop_front();
            chk1({tag, "_valid"}, id_valid, 1'b1);
            chk8({tag, "_pc"}, id_pc, e);
            chk8({tag, "_ins"}, id_ins, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst       = 1'b1;
        pc_en     = 1'b1;
        pc_sel    = 2'b00;
        br_target = 8'h00;
        lr_we     = 1'b0;
        mem_auto  = 1'b1;
        ack_man   = 1'b0;
        data_man  = 8'h00;

        // Reset state
        tick();
        tick();
        chk1("rst_valid", id_valid, 1'b0);
        chk8("rst_id_pc", id_pc, 8'h00);
        chk8("rst_id_ins", id_ins, 8'h00);
        chk8("rst_lr", lr, 8'h00);
        chk1("rst_req_low", imem_req, 1'b0);

        rst = 1'b0;
        settle();
        chk1("first_req", imem_req, 1'b1);
        chk8("first_addr", imem_addr, 8'h00);

        // Streaming at one instruction per cycle
        for (int i = 0; i < 6; i++) exp_q.push_back(8'(i));
        for (int i = 0; i < 6; i++) begin
            tick();
            check_id("stream");
        end

        // Stall while id_pc = 05: exactly D further fetches, IF/ID holds
        pc_en = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            if (imem_req && imem_ack) begin
                chk8("stall_fetch_addr", imem_addr, 8'(6 + n_acc));
                n_acc++;
            end
            tick();
            chk8("stall_hold_pc", id_pc, 8'h05);
            chk1("stall_hold_valid", id_valid, 1'b1);
        end
        chk8("stall_fetch_count", 8'(n_acc), 8'(D));

        pc_en = 1'b1;
        for (int i = 6; i < 10; i++) exp_q.push_back(8'(i));
        for (int i = 0; i < 4; i++) begin
            tick();
            check_id("release");
        end

        // Redirect to 40 with a stray ack in the redirect cycle
        mem_auto  = 1'b0;
        ack_man   = 1'b1;
        data_man  = imem_addr;
        pc_sel    = 2'b01;
        br_target = 8'h40;
        settle();
        chk1("redir_req_low", imem_req, 1'b0);
        tick();
        pc_sel   = 2'b00;
        mem_auto = 1'b1;
        ack_man  = 1'b0;
        chk1("redir_flush_valid", id_valid, 1'b0);
        settle();
        chk1("redir_req", imem_req, 1'b1);
        chk8("redir_addr", imem_addr, 8'h40);
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h41);
        tick();
        check_id("redir_target");
        tick();
        check_id("redir_next");

        // Link register: capture at id_pc = 12, return through lr
        pc_sel    = 2'b01;
        br_target = 8'h11;
        tick();
        pc_sel = 2'b00;
        chk1("lr_redir_valid", id_valid, 1'b0);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h13);
        tick();
        check_id("lr_pre");
        tick();
        check_id("lr_at12");
        lr_we = 1'b1;
        tick();
        lr_we = 1'b0;
        chk8("lr_load", lr, 8'h13);
        check_id("lr_after");

        // Redirect through lr together with lr_we: old lr wins the redirect
        pc_sel = 2'b10;
        lr_we  = 1'b1;
        tick();
        pc_sel = 2'b00;
        lr_we  = 1'b0;
        chk8("lr_new_value", lr, 8'h14);
        chk1("lr_redir_valid2", id_valid, 1'b0);
        chk8("lr_redir_addr", imem_addr, 8'h13);
        exp_q.push_back(8'h13);
        tick();
        check_id("lr_return");

        // Address wrap and lr wrap
        pc_sel    = 2'b01;
        br_target = 8'hFE;
        tick();
        pc_sel = 2'b00;
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        tick();
        check_id("wrap_fe");
        tick();
        check_id("wrap_ff");
        chk8("wrap_addr", imem_addr, 8'h00);
        lr_we = 1'b1;
        tick();
        lr_we = 1'b0;
        chk8("lr_wrap", lr, 8'h00);
        check_id("wrap_00");

        // Reset mid-request; the ack arrives three cycles late, during reset
        mem_auto = 1'b0;
        ack_man  = 1'b0;
        tick();
        chk1("pend_req", imem_req, 1'b1);
        chk8("pend_addr_stable", imem_addr, 8'h01);
        chk1("pend_id_cleared", id_valid, 1'b0);
        rst = 1'b1;
        settle();
        chk1("rst_mid_req_low", imem_req, 1'b0);
        tick();
        tick();
        ack_man  = 1'b1;
        data_man = 8'h01;
        settle();
        chk1("late_ack_req_low", imem_req, 1'b0);
        tick();
        chk1("rst2_valid", id_valid, 1'b0);
        chk8("rst2_lr", lr, 8'h00);
        chk8("rst2_id_pc", id_pc, 8'h00);
        rst      = 1'b0;
        ack_man  = 1'b0;
        mem_auto = 1'b1;
        settle();
        chk1("post_rst_req", imem_req, 1'b1);
        chk8("post_rst_addr", imem_addr, 8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        tick();
        check_id("post_rst_0");
        tick();
        check_id("post_rst_1");

        chk8("scoreboard_drained", 8'(exp_q.size()), 8'h00);

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on posedge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port pc_en, input, 1 bit: 1 = ID may accept a new instruction; 0 = stall, hold IF/ID (driven by bubble control).
REQ-004 SHALL have port pc_sel, input, 2 bits: 00 sequential, 01 redirect to br_target, 10 redirect to link register, 11 treated as 00.
REQ-005 SHALL have port br_target, input, 8 bits: branch target address.
REQ-006 SHALL have port lr_we, input, 1 bit: capture return address id_pc+1 into the internal link register.
REQ-007 SHALL have port imem_req, output, 1 bit: instruction fetch request, held until accepted.
REQ-008 SHALL have port imem_addr, output, 8 bits: fetch address, stable while imem_req=1 and not acknowledged.
REQ-009 SHALL have port imem_ack, input, 1 bit: request accepted and data valid; may assert in the same cycle as imem_req.
REQ-010 SHALL have port imem_data, input, 8 bits: instruction, sampled at a posedge where imem_req&imem_ack.
REQ-011 SHALL have port id_ins, output, 8 bits: IF/ID instruction register.
REQ-012 SHALL have port id_pc, output, 8 bits: address of id_ins.
REQ-013 SHALL have port id_valid, output, 1 bit: id_ins/id_pc hold a live instruction.
REQ-014 SHALL have port lr, output, 8 bits: current link register value.

Function
REQ-015 SHALL keep fetch PC fpc; fpc increments by 1 on each accepted request (imem_req&imem_ack), wrapping 8'hFF->8'h00; imem_addr=fpc.
REQ-016 SHALL hold at most one outstanding request and buffer returned instructions in a FIFO of depth D (D=1 by default; see REQ-027).
REQ-017 SHALL assert imem_req only when (FIFO occupancy + id slot pending) leaves room for the returned word, with no redirect in the current cycle.
REQ-018 On accept with FIFO empty and (pc_en=1 or id_valid=0), data SHALL go directly to IF/ID (latency: id_valid=1 on the posedge after ack); otherwise it SHALL be written into the FIFO.
REQ-019 When pc_en=1, IF/ID SHALL load the FIFO head if nonempty, else direct data per REQ-018, else clear id_valid.
REQ-020 When pc_en=0 and no redirect, IF/ID SHALL hold all values; FIFO SHALL keep filling until full.
REQ-021 Redirect (pc_sel=01/10) SHALL, at the next posedge: set fpc to br_target or lr, clear id_valid, empty the FIFO, and drop any data acknowledged in that cycle; first request to the new address SHALL issue the cycle after.
REQ-022 Priority SHALL be rst > redirect > stall > sequential; redirect during pc_en=0 flushes.
REQ-023 lr_we=1 SHALL load lr <= id_pc+1 (mod 256); with simultaneous pc_sel=10 the redirect SHALL use the old lr.
REQ-024 Sustained throughput SHALL be one instruction per cycle with zero-wait memory and pc_en=1.

Reset
REQ-025 rst=1 at a posedge SHALL set fpc=0, lr=0, id_ins=0, id_pc=0, id_valid=0, FIFO empty, no outstanding request; imem_req SHALL be 0 while rst=1.
REQ-026 rst asserted mid-request SHALL abandon the request; data acknowledged in that cycle SHALL be discarded; first request after rst deasserts SHALL be address 0.

Configuration
REQ-027 Macro FETCH_PREFETCH_BUF_EN SHALL, when defined, set FIFO depth D=2 so fetching continues for two words under stall; when undefined, D=1 and fetching stops once one word is buffered.

Verification
REQ-028 Zero-wait memory returning data=addr, rst released, pc_en=1 -> id_pc/id_ins = 00,01,02,... on consecutive cycles, id_valid=1 from first cycle after release.
REQ-029 pc_en=0 for 4 cycles while id_pc=05 -> id_pc holds 05; exactly D further requests issued (06; plus 07 if FETCH_PREFETCH_BUF_EN); after release, id_pc=06,07,... with no gap or duplicate.
REQ-030 pc_sel=01, br_target=8'h40 while request to 0A outstanding and acked that cycle -> data for 0A dropped, id_valid=0 next cycle, next request addr 40, id_pc=40 follows.
REQ-031 lr_we=1 with id_pc=8'h12, later pc_sel=10 -> lr=13, next fetched id_pc=13; lr_we with id_pc=FF -> lr=00.
REQ-032 fpc=FF sequential -> following request address 00; rst pulse with imem_ack delayed 3 cycles -> late data ignored, first post-reset id_pc=00.
